// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 2-flop input synchronizers, start-bit glitch rejection, LSB-first data.
// Optional even-parity check is enabled by defining UART_RX_PARITY_EN (adds parity_err).
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  // The stop bit is counted in blocks of 16 strobes; n tracks the block index.
  localparam logic [2:0] LAST_BLK = 3'(SB_TICKS / 16 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } state_t;
`endif

  state_t                 r_state, w_state_nx;
  logic [3:0]             r_s, w_s_nx;
  logic [2:0]             r_n, w_n_nx;
  logic [DATA_BITS-1:0]   r_b, w_b_nx;
  logic [DATA_BITS-1:0]   w_dout_nx;
  logic                   w_done_nx;
  logic                   w_ferr_nx;
  logic                   r_rx_s1, r_rx_s2, r_rx_d;
  logic                   r_tick_s1, r_tick_s2, r_tick_d;
  logic                   w_strobe;
  logic                   w_fall;
`ifdef UART_RX_PARITY_EN
  logic                   r_par, w_par_nx;
  logic                   w_perr_nx;
`endif

  // Input synchronizers plus one delayed copy of each for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_d    <= 1'b1;
      r_tick_s1 <= 1'b0;
      r_tick_s2 <= 1'b0;
      r_tick_d  <= 1'b0;
    end else begin
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_d    <= r_rx_s2;
      r_tick_s1 <= tick;
      r_tick_s2 <= r_tick_s1;
      r_tick_d  <= r_tick_s2;
    end
  end

  assign w_strobe = r_tick_s2 & ~r_tick_d;
  assign w_fall   = r_rx_d & ~r_rx_s2;

  // State, counters, shift register and registered output pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_s       <= 4'd0;
      r_n       <= 3'd0;
      r_b       <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_s       <= w_s_nx;
      r_n       <= w_n_nx;
      r_b       <= w_b_nx;
      dout      <= w_dout_nx;
      rx_done   <= w_done_nx;
      frame_err <= w_ferr_nx;
`ifdef UART_RX_PARITY_EN
      r_par      <= w_par_nx;
      parity_err <= w_perr_nx;
`endif
    end
  end

  // Next-state, counter and output logic; every field held unless a strobe acts on it.
  always_comb begin
    w_state_nx = r_state;
    w_s_nx     = r_s;
    w_n_nx     = r_n;
    w_b_nx     = r_b;
    w_dout_nx  = dout;
    w_done_nx  = 1'b0;
    w_ferr_nx  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nx   = r_par;
    w_perr_nx  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nx = ST_START;
          w_s_nx     = 4'd0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_strobe && (r_s == 4'd7)) begin
          w_s_nx     = 4'd0;
          w_n_nx     = 3'd0;
          w_state_nx = r_rx_s2 ? ST_IDLE : ST_DATA;
        end else if (w_strobe) begin
          w_s_nx = r_s + 4'd1;
        end else begin
          w_s_nx = r_s;
        end
      end
      ST_DATA: begin
        if (w_strobe && (r_s == 4'd15)) begin
          w_s_nx = 4'd0;
          w_b_nx = {r_rx_s2, r_b[DATA_BITS-1:1]};
          if (r_n == LAST_BIT) begin
            w_n_nx = 3'd0;
`ifdef UART_RX_PARITY_EN
            w_state_nx = ST_PARITY;
`else
            w_state_nx = ST_STOP;
`endif
          end else begin
            w_n_nx = r_n + 3'd1;
          end
        end else if (w_strobe) begin
          w_s_nx = r_s + 4'd1;
        end else begin
          w_s_nx = r_s;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_strobe && (r_s == 4'd15)) begin
          w_s_nx     = 4'd0;
          w_par_nx   = r_rx_s2;
          w_state_nx = ST_STOP;
        end else if (w_strobe) begin
          w_s_nx = r_s + 4'd1;
        end else begin
          w_s_nx = r_s;
        end
      end
`endif
      ST_STOP: begin
        if (w_strobe && (r_s == 4'd15) && (r_n == LAST_BLK)) begin
          w_s_nx     = 4'd0;
          w_n_nx     = 3'd0;
          w_state_nx = ST_IDLE;
          // Framing error wins over a parity mismatch; dout only moves on a clean frame.
          if (!r_rx_s2) begin
            w_ferr_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (^{r_b, r_par}) begin
            w_perr_nx = 1'b1;
`endif
          end else begin
            w_dout_nx = r_b;
            w_done_nx = 1'b1;
          end
        end else if (w_strobe && (r_s == 4'd15)) begin
          w_s_nx = 4'd0;
          w_n_nx = r_n + 3'd1;
        end else if (w_strobe) begin
          w_s_nx = r_s + 4'd1;
        end else begin
          w_s_nx = r_s;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_s_nx     = 4'd0;
        w_n_nx     = 3'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames driven against the bench's own tick, pulses counted by a monitor.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  int         perr_cnt = 0;
`endif

  int checks = 0;
  int failures = 0;
  int tick_hi = 82;
  int tick_lo = 81;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int viol_cnt = 0;
  logic prev_done = 1'b0;
  logic prev_ferr = 1'b0;
  logic [7:0] done_q[$];

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  // 50 MHz system clock.
  always #10 clk = ~clk;

  initial begin
    forever begin
      repeat (tick_lo) @(negedge clk);
      tick = 1'b1;
      repeat (tick_hi) @(negedge clk);
      tick = 1'b0;
    end
  end

  // Pulse monitor: counts pulses, records dout per rx_done, flags overlap or stretched pulses.
  always @(negedge clk) begin
    if (rx_done && frame_err) viol_cnt <= viol_cnt + 1;
    if (rx_done && prev_done) viol_cnt <= viol_cnt + 1;
    if (frame_err && prev_ferr) viol_cnt <= viol_cnt + 1;
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      done_q.push_back(dout);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt <= perr_cnt + 1;
`endif
    prev_done <= rx_done;
    prev_ferr <= frame_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (16) @(posedge tick);
  endtask

  task automatic idle_bits(input int nb);
    rx = 1'b1;
    repeat (16 * nb) @(posedge tick);
    #1;
  endtask

  // Leaves rx at the stop value so a break can follow a bad stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_ok = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_ok ? ^d : ~^d);
`else
    if (par_ok) rx = 1'b1;
    else rx = 1'b1;
`endif
    send_bit(stop_v);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    #1;
    check_eq("reset_dout", 32'(dout), 32'h0);
    check_eq("reset_rx_done", 32'(rx_done), 32'h0);
    check_eq("reset_frame_err", 32'(frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // 19200 baud at 50 MHz: one tick every 163 clocks.
    idle_bits(1);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    check_eq("a5_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("a5_dout", 32'(dout), 32'hA5);
    check_eq("a5_q0", 32'(done_q[0]), 32'hA5);
    check_eq("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);

    tick_hi = 4;
    tick_lo = 4;
    idle_bits(1);

    rx = 1'b0;
    repeat (4) @(posedge tick);
    idle_bits(2);
    check_eq("glitch_no_done", 32'(done_cnt), 32'd1);
    check_eq("glitch_no_ferr", 32'(ferr_cnt), 32'd0);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    check_eq("3c_done_cnt", 32'(done_cnt), 32'd2);
    check_eq("3c_dout", 32'(dout), 32'h3C);

    // Bad stop bit followed by a held-low break: one error only, no restart.
    send_frame(8'h5A, 1'b0);
    repeat (40) @(posedge tick);
    idle_bits(2);
    check_eq("5a_ferr_cnt", 32'(ferr_cnt), 32'd1);
    check_eq("5a_no_done", 32'(done_cnt), 32'd2);
    check_eq("5a_dout_kept", 32'(dout), 32'h3C);
    send_frame(8'h11, 1'b1);
    idle_bits(1);
    check_eq("11_done_cnt", 32'(done_cnt), 32'd3);
    check_eq("11_dout", 32'(dout), 32'h11);

    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    repeat (8) @(posedge tick);
    rst = 1'b0;
    #1;
    check_eq("midrst_dout", 32'(dout), 32'h0);
    check_eq("midrst_rx_done", 32'(rx_done), 32'h0);
    check_eq("midrst_frame_err", 32'(frame_err), 32'h0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    idle_bits(8);
    check_eq("midrst_no_done", 32'(done_cnt), 32'd3);
    check_eq("midrst_no_ferr", 32'(ferr_cnt), 32'd1);
    check_eq("midrst_dout_hold", 32'(dout), 32'h0);
    send_frame(8'h81, 1'b1);
    idle_bits(1);
    check_eq("81_done_cnt", 32'(done_cnt), 32'd4);
    check_eq("81_dout", 32'(dout), 32'h81);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle_bits(1);
    check_eq("b2b_done_cnt", 32'(done_cnt), 32'd6);
    check_eq("b2b_first", 32'(done_q[4]), 32'h00);
    check_eq("b2b_second", 32'(done_q[5]), 32'hFF);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(1);
    check_eq("par_bad_perr", 32'(perr_cnt), 32'd1);
    check_eq("par_bad_no_done", 32'(done_cnt), 32'd6);
    check_eq("par_bad_dout", 32'(dout), 32'hFF);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(1);
    check_eq("par_ok_done", 32'(done_cnt), 32'd7);
    check_eq("par_ok_dout", 32'(dout), 32'h07);
    check_eq("par_ok_perr", 32'(perr_cnt), 32'd1);
`endif

    check_eq("pulse_shape_viol", 32'(viol_cnt), 32'd0);
    check_eq("total_ferr", 32'(ferr_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
